// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: FIFO-buffered word pacer feeding a UART transmitter, one frame plus gap per word.
// Ports: txclk/reset (sync, active-high); wr_valid/wr_ready/wr_data host write side;
// tx_data/tx_enable/tx_load registered transmitter side; busy/empty/full status; overflow pulse on refused write.
// Optional macro UART_TX_FEEDER_LEVEL_EN adds output level, the registered FIFO count.
module uart_tx_feeder #(
  parameter int DATA_W = 9,
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter int FRAME_CYCLES = 12,
  parameter int GAP_CYCLES = 1
) (
  input  logic txclk,
  input  logic reset,
  input  logic wr_valid,
  output logic wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] tx_data,
  output logic tx_enable,
  output logic tx_load,
  output logic busy,
  output logic empty,
  output logic full,
  output logic overflow
`ifdef UART_TX_FEEDER_LEVEL_EN
  ,
  output logic [ADDR_W:0] level
`endif
);
  localparam int FW = FRAME_CYCLES > 1 ? $clog2(FRAME_CYCLES) : 1;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0] count_q, count_d;
  logic [FW-1:0] frame_cnt_q;
  logic [GW-1:0] gap_cnt_q;
  logic [DATA_W-1:0] tx_data_q;
  logic tx_enable_q, tx_load_q, overflow_q, push, pop;
  assign full = count_q == (ADDR_W+1)'(DEPTH);
  assign empty = count_q == '0;
  assign busy = state_q != IDLE;
  assign wr_ready = !full && !reset;
  assign push = wr_valid && wr_ready;
  // count_q is registered, so a word written this edge is only poppable from the next one
  assign pop = state_q == IDLE && !empty;
  assign tx_data = tx_data_q;
  assign tx_enable = tx_enable_q;
  assign tx_load = tx_load_q;
  assign overflow = overflow_q;
`ifdef UART_TX_FEEDER_LEVEL_EN
  assign level = count_q;
`endif
  always_comb count_d = push && !pop ? count_q + 1'b1 : !push && pop ? count_q - 1'b1 : count_q;
  always_ff @(posedge txclk) if (push) mem_q[wr_ptr_q] <= wr_data;
  always_ff @(posedge txclk)
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_q <= count_d;
      overflow_q <= wr_valid && !wr_ready;
    end
  always_ff @(posedge txclk)
    if (reset) begin
      state_q <= IDLE;
      tx_data_q <= '0;
      tx_enable_q <= 1'b0;
      tx_load_q <= 1'b0;
      frame_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else
      case (state_q)
        IDLE: if (pop) begin
          tx_data_q <= mem_q[rd_ptr_q];
          tx_enable_q <= 1'b1;
          tx_load_q <= 1'b1;
          frame_cnt_q <= FW'(FRAME_CYCLES - 1);
          state_q <= SEND;
        end
        SEND: begin
          tx_load_q <= 1'b0;
          if (frame_cnt_q == '0) begin
            tx_enable_q <= 1'b0;
            gap_cnt_q <= GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
            state_q <= GAP_CYCLES == 0 ? IDLE : GAP;
          end else frame_cnt_q <= frame_cnt_q - 1'b1;
        end
        GAP: if (gap_cnt_q == '0) state_q <= IDLE;
          else gap_cnt_q <= gap_cnt_q - 1'b1;
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: scoreboard bench for uart_tx_feeder against a queue/timer reference model.
module tb_uart_tx_feeder;
  localparam int DW = 9, DEPTH = 16, AW = 4, FRAME = 12, GAP = 1, PERIOD = FRAME + GAP + 1;
  logic txclk = 1'b0, reset = 1'b1, wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic wr_ready, tx_enable, tx_load, busy, empty, full, overflow;
  logic [DW-1:0] tx_data;
`ifdef UART_TX_FEEDER_LEVEL_EN
  logic [AW:0] level;
`endif
  uart_tx_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .FRAME_CYCLES(FRAME), .GAP_CYCLES(GAP)) dut (
    .txclk(txclk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .tx_data(tx_data), .tx_enable(tx_enable), .tx_load(tx_load), .busy(busy), .empty(empty),
    .full(full), .overflow(overflow)
`ifdef UART_TX_FEEDER_LEVEL_EN
    , .level(level)
`endif
  );
  always #5 txclk = ~txclk;
  int compared = 0, mismatched = 0;
  int cyc = 0, cnt_m = 0, left_m = 0, acc_cyc = 0, n_tx = 0, n_ovf = 0, n_full = 0, en_run = 0;
  bit ovf_m = 0, load_m = 0, acc_m = 0, mon_on = 0;
  logic [DW-1:0] sb_q[$];
  int load_cyc[$];
  logic [DW-1:0] last_tx = '0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Reference model: cnt_m words waiting, left_m cycles until the pacer can take the next word.
  // A word is taken when nothing is in flight; a frame plus gap then occupies FRAME+GAP more edges.
  always @(posedge txclk) begin
    cyc++;
    if (reset) begin
      cnt_m = 0; left_m = 0; ovf_m = 0; load_m = 0;
      sb_q.delete();
    end else begin
      acc_m = wr_valid && cnt_m < DEPTH;
      ovf_m = wr_valid && cnt_m == DEPTH;
      load_m = left_m == 0 && cnt_m > 0;
      if (load_m) begin cnt_m--; left_m = FRAME + GAP; end
      else if (left_m > 0) left_m--;
      if (acc_m) begin cnt_m++; sb_q.push_back(wr_data); acc_cyc = cyc; end
    end
  end
  // Monitor: samples just after each edge, compares against model and scoreboard.
  always @(posedge txclk) begin
    #1;
    if (mon_on) begin
      chk("wr_ready", wr_ready, !reset && cnt_m < DEPTH);
      chk("empty", empty, cnt_m == 0);
      chk("full", full, cnt_m == DEPTH);
      chk("busy", busy, left_m > 0);
      chk("tx_enable", tx_enable, left_m > GAP);
      chk("tx_load", tx_load, load_m);
      chk("overflow", overflow, ovf_m);
      if (tx_load === 1'b1) begin
        if (sb_q.size() == 0) chk("spurious_load", tx_load, 0);
        else chk("tx_data_order", tx_data, sb_q.pop_front());
        last_tx = tx_data;
        load_cyc.push_back(cyc);
        n_tx++;
      end else if (tx_enable === 1'b1) chk("tx_data_stable", tx_data, last_tx);
      if (full === 1'b1) n_full++;
      if (overflow === 1'b1) n_ovf++;
      if (tx_enable === 1'b1) en_run++;
      else begin
        if (en_run > 0 && !reset) chk("frame_len", en_run, FRAME);
        en_run = 0;
      end
    end
  end
  task automatic tick(int n);
    repeat (n) @(negedge txclk);
  endtask
  task automatic write1(logic [DW-1:0] d);
    wr_valid = 1'b1; wr_data = d;
    @(negedge txclk);
    wr_valid = 1'b0;
  endtask
  task automatic put(logic [DW-1:0] d);
    int t = 0;
    while (wr_ready !== 1'b1 && t < 200) begin @(negedge txclk); t++; end
    if (t >= 200) chk("put_timeout", wr_ready, 1);
    write1(d);
  endtask
  task automatic drain();
    int t = 0;
    while ((cnt_m > 0 || left_m > 0) && t < 1000) begin @(negedge txclk); t++; end
    if (t >= 1000) chk("drain_timeout", busy, 0);
    tick(2);
  endtask
  task automatic wait_load(int n0);
    int t = 0;
    while (n_tx == n0 && t < 100) begin @(negedge txclk); t++; end
    if (t >= 100) chk("load_timeout", n_tx - n0, 1);
  endtask
  initial begin
    int n0, l0, o0, k;
    tick(1);
    mon_on = 1;
    tick(2);
    reset = 1'b0;
    tick(50);
    chk("idle_tx_data", tx_data, 0);
    chk("idle_wr_ready", wr_ready, 1);
    // single word: sampled at edge E, tx_enable/tx_load appear after edge E+1
    n0 = n_tx;
    write1(9'h1A5);
    wait_load(n0);
    chk("single_latency", load_cyc[$] - acc_cyc, 1);
    chk("single_data", last_tx, 9'h1A5);
    drain();
    chk("single_count", n_tx - n0, 1);
    chk("single_idle", busy, 0);
    // burst ordering and period
    n0 = n_tx; l0 = load_cyc.size();
    write1(9'h001); write1(9'h0FF); write1(9'h155);
    drain();
    chk("burst_count", n_tx - n0, 3);
    if (load_cyc.size() >= l0 + 3) begin
      chk("burst_period1", load_cyc[l0+1] - load_cyc[l0], PERIOD);
      chk("burst_period2", load_cyc[l0+2] - load_cyc[l0+1], PERIOD);
    end
    chk("burst_empty", empty, 1);
    // fill to full, then one refused write
    write1(9'h100);
    k = 1;
    while (cnt_m < DEPTH && k < 40) begin write1(DW'(9'h100 + k)); k++; end
    chk("full_flag", full, 1);
    chk("full_wr_ready", wr_ready, 0);
    o0 = n_ovf;
    write1(9'h1EE);
    tick(3);
    chk("ovf_pulses", n_ovf - o0, 1);
    drain();
    chk("ovf_sb_empty", sb_q.size(), 0);
    // wrap-around stream, mixed with random idle gaps
    n0 = n_tx;
    for (int i = 0; i < 40; i++) begin
      put(DW'(i));
      if ($urandom_range(3) == 0) tick($urandom_range(4));
    end
    drain();
    chk("wrap_count", n_tx - n0, 40);
    chk("wrap_sb_empty", sb_q.size(), 0);
    // random words, random spacing
    n0 = n_tx; k = 0;
    for (int i = 0; i < 20; i++) begin
      if (wr_ready === 1'b1) k++;
      write1(DW'($urandom));
      tick($urandom_range(20));
    end
    drain();
    chk("rand_count", n_tx - n0, k);
    // reset mid-frame with three words queued
    n0 = n_tx;
    write1(9'h0AA); write1(9'h0BB); write1(9'h0CC); write1(9'h0DD);
    wait_load(n0);
    tick(5);
    chk("pre_rst_enable", tx_enable, 1);
    reset = 1'b1;
    tick(1);
    chk("rst_tx_enable", tx_enable, 0);
    chk("rst_empty", empty, 1);
    tick(1);
    reset = 1'b0;
    n0 = n_tx;
    tick(60);
    chk("post_rst_no_tx", n_tx - n0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
